// File: rtl/r200lsu.sv
// r200lsu: memory-stage load/store unit for the r200 5-stage RV32 pipeline.
//
// Takes the ex_mem slot (address, store data, func3, memrd/memwr), runs one access on a
// req/ack data bus, extends load data, and hands the result toward mem_wb as a one-cycle
// rsp_valid pulse. The pipeline is stalled while a request is being accepted and while the bus
// access is outstanding. Stall drops in the cycle that carries the response.
//
// Parameters
//   TIMEOUT    bus cycles bus_req may wait for bus_ack before the access is aborted (>= 1)
//
// Optional feature (compile-time macro)
//   R200_LSU_MISALIGN_EN  defined: misaligned halfword/word accesses never reach the bus. They
//                         complete one cycle after accept with rsp_err=1 and misalign=1.
//                         undefined: misalign is tied 0 and the low address bits are forced
//                         aligned to the access size.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    ex_mem slot valid / unit idle and able to accept
//   req_memrd, req_memwr   load / store (store wins when both are set)
//   req_func3              RV32 width and sign field
//   req_addr, req_wdata    byte address, store data
//   stall                  freeze IF..MEM pipeline registers
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata              extended load data (0 for stores and errors), held until next response
//   rsp_err, misalign      abort flags, qualified by rsp_valid, held until next response
//   bus_req/bus_ack        bus handshake; bus_rdata valid in the bus_ack cycle
//   bus_we, bus_addr       write strobe, word-aligned address
//   bus_wdata, bus_be      lane-replicated store data, byte enables
module r200lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_memrd,
    input  logic        req_memwr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter only has to reach TIMEOUT-1: the abort happens on the TIMEOUT-th waiting cycle.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;

    // Attributes of the access in flight, captured at accept.
    logic [1:0]      op_lane;
    logic [1:0]      op_size;
    logic            op_uns;
    logic            op_store;

    logic            accept;
    logic            is_half;
    logic            is_word;
    logic [1:0]      lane;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;

`ifdef R200_LSU_MISALIGN_EN
    logic            addr_bad;
    logic            misalign_q;
`endif

    // func3[1:0]: 00 byte, 01 half, 1x word (covers 010 and the reserved 011/110/111).
    // func3[2] selects zero extension for loads.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  ln,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extend = {{24{b[7] & ~uns}}, b};
            2'b01:   load_extend = {{16{h[15] & ~uns}}, h};
            default: load_extend = word;
        endcase
    endfunction

    always_comb begin
        accept  = req_valid & (req_memrd | req_memwr);
        is_half = (req_func3[1:0] == 2'b01);
        is_word = req_func3[1];
`ifdef R200_LSU_MISALIGN_EN
        addr_bad = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
        lane     = req_addr[1:0];
`else
        // Without misalign detection the access is silently aligned to its size.
        if (is_word) begin
            lane = 2'b00;
        end else if (is_half) begin
            lane = {req_addr[1], 1'b0};
        end else begin
            lane = req_addr[1:0];
        end
`endif
    end

    // Byte enables and replicated store data; loads read the whole word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = 32'd0;
        if (req_memwr) begin
            case (req_func3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << lane;
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {lane[1], 1'b0};
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            op_lane   <= 2'b00;
            op_size   <= 2'b00;
            op_uns    <= 1'b0;
            op_store  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'b0000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
`ifdef R200_LSU_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        cnt       <= '0;
                        op_lane   <= lane;
                        op_size   <= req_func3[1:0];
                        op_uns    <= req_func3[2];
                        op_store  <= req_memwr;
                        bus_we    <= req_memwr;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_wdata <= wdata_d;
                        bus_be    <= be_d;
`ifdef R200_LSU_MISALIGN_EN
                        if (addr_bad) begin
                            // Rejected without touching the bus.
                            bus_req    <= 1'b0;
                            rsp_valid  <= 1'b1;
                            rsp_rdata  <= 32'd0;
                            rsp_err    <= 1'b1;
                            misalign_q <= 1'b1;
                            state      <= StDone;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= StBus;
                        end
`else
                        bus_req <= 1'b1;
                        state   <= StBus;
`endif
                    end
                end

                StBus: begin
                    // Ack is checked first so an ack on the last allowed cycle still succeeds.
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= op_store ? 32'd0
                                              : load_extend(bus_rdata, op_lane, op_size, op_uns);
                        rsp_err   <= 1'b0;
`ifdef R200_LSU_MISALIGN_EN
                        misalign_q <= 1'b0;
`endif
                        state     <= StDone;
                    end else if (cnt == CntLast) begin
                        bus_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
`ifdef R200_LSU_MISALIGN_EN
                        misalign_q <= 1'b0;
`endif
                        state     <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StDone: begin
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end

                default: begin
                    bus_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

`ifdef R200_LSU_MISALIGN_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign req_ready = (state == StIdle);
    assign stall     = ((state == StIdle) && accept) || (state == StBus);

endmodule
